inst_fetch: RTL and testbench

Instruction fetch stage of the three-stage pipeline and the producer side of the fetch→decode interface. Holds the PC, issues one 32-bit read at a time to instruction memory over a valid/ready request with a valid-only response, and presents each fetched word with its PC to decode through a one-entry output register. Accepts redirects from the execute stage for taken branches and jumps, flushes the output register, and discards any stale in-flight response.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/inst_fetch.sv | 143 ++++++++++++++
 tb/tb_inst_fetch.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch sequencer states: issue a request, wait for its data, or
    // swallow a response that a redirect made stale.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem request, fetch->decode register.
module inst_fetch
    import fetch_pkg::fetch_state_e;
    import fetch_pkg::S_REQ;
    import fetch_pkg::S_WAIT;
    import fetch_pkg::S_DRAIN;
    import fetch_pkg::NOP_INSTR;
    import fetch_pkg::PC_STEP;
#(
    parameter int unsigned     XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            fd_valid,
    input  logic            fd_ready,
    output logic [XLEN-1:0] fd_instruction,
    output logic [XLEN-1:0] fd_pc
);

    localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic            fd_valid_q, fd_valid_d;
    logic [XLEN-1:0] fd_instr_q, fd_instr_d;
    logic [XLEN-1:0] fd_pc_q, fd_pc_d;

    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            unused_redirect_lsbs;

    // Redirect targets are word aligned; the low bits carry no information.
    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Only issue when the output register can take the response when it lands.
    assign imem_req_valid = (state_q == S_REQ) && !redirect_valid && !reset
                            && (!fd_valid_q || fd_ready);
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fd_valid       = fd_valid_q;
    assign fd_instruction = fd_instr_q;
    assign fd_pc          = fd_pc_q;

    // State, PC and output register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= PC_INIT;
            discard_q  <= 1'b0;
            fd_valid_q <= 1'b0;
            fd_instr_q <= XLEN'(NOP_INSTR);
            fd_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            fd_valid_q <= fd_valid_d;
            fd_instr_q <= fd_instr_d;
            fd_pc_q    <= fd_pc_d;
        end
    end

    // Next-state: redirect overrides normal sequencing and flushes decode.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        fd_valid_d = fd_valid_q;
        fd_instr_d = fd_instr_q;
        fd_pc_d    = fd_pc_q;

        if (fd_valid_q && fd_ready) begin
            fd_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d       = redirect_target;
            fd_valid_d = 1'b0;
            unique case (state_q)
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d   = S_DRAIN;
                        discard_d = 1'b1;
                    end
                end
                S_DRAIN: begin
                    // A stale response arriving now retires the outstanding
                    // request, so the new target can be fetched right away.
                    if (imem_rsp_valid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        fd_instr_d = imem_rsp_data;
                        fd_pc_d    = pc_q;
                        fd_valid_d = 1'b1;
                        pc_d       = pc_q + XLEN'(PC_STEP);
                        state_d    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed fetch, stall, redirect and reset scenarios.
module tb_inst_fetch;

    import fetch_pkg::*;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_instruction;
    logic [31:0] fd_pc;

    inst_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_instruction (fd_instruction),
        .fd_pc          (fd_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_fd_q[$];

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    // Memory image: each word encodes its own low address bits.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'hA5A5_0000 | {16'h0000, a[15:0]};
    endfunction

    // Instruction memory model with programmable latency (>= 1 cycle).
    int          lat = 1;
    int          mem_cnt;
    bit          mem_pend;
    bit          hs_s;
    bit          rst_s;
    logic [31:0] addr_s;
    logic [31:0] mem_addr;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_pend       = 1'b0;
        mem_cnt        = 0;
        mem_addr       = '0;
        forever begin
            @(negedge clock);
            hs_s   = imem_req_valid && imem_req_ready;
            addr_s = imem_addr;
            rst_s  = reset;
            @(posedge clock);
            #1;
            imem_rsp_valid = 1'b0;
            if (rst_s) begin
                mem_pend = 1'b0;
            end else begin
                if (hs_s) begin
                    if (mem_pend) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL req_while_pending: got request at %h expected none", addr_s);
                    end
                    mem_pend = 1'b1;
                    mem_cnt  = lat;
                    mem_addr = addr_s;
                end
                if (mem_pend) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(mem_addr);
                        mem_pend       = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compare every request and every decode handshake against the queues.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (imem_req_valid && imem_req_ready) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_unexpected: got addr %h expected none", imem_addr);
                end else begin
                    chk32("req_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (fd_valid && fd_ready) begin
                if (exp_fd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fd_unexpected: got pc %h instr %h expected none", fd_pc, fd_instruction);
                end else begin
                    e = exp_fd_q.pop_front();
                    chk32("fd_pc", fd_pc, e[63:32]);
                    chk32("fd_instr", fd_instruction, e[31:0]);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int k);
        repeat (k) sync();
    endtask

    task automatic wait_hs();
        bit found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk1("hs_seen", found, 1'b1);
    endtask

    task automatic fetch_n(input int n, output int span);
        int cnt   = 0;
        int first = 0;
        span = -1;
        sync();
        imem_req_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clock);
            if (imem_req_valid && imem_req_ready) begin
                if (cnt == 0) first = cyc;
                cnt++;
                if (cnt == n) begin
                    span = cyc - first;
                    break;
                end
            end
        end
        chk32("fetch_count", 32'(cnt), 32'(n));
        sync();
        imem_req_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int  span;
        bit  got;

        reset          = 1'b1;
        imem_req_ready = 1'b0;
        fd_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        @(negedge clock);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        sync();
        sync();
        reset = 1'b0;
        @(negedge clock);
        chk1 ("rst_fd_valid", fd_valid, 1'b0);
        chk32("rst_fd_instr", fd_instruction, 32'h0000_0013);
        chk32("rst_fd_pc", fd_pc, 32'h0);
        chk32("rst_addr", imem_addr, 32'h0);
        chk1 ("rst_req_after", imem_req_valid, 1'b1);

        // Streaming fetch, 1-cycle memory: one word per two cycles
        lat = 1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        exp_fd_q.push_back({32'h0, 32'hA5A5_0000});
        exp_fd_q.push_back({32'h4, 32'hA5A5_0004});
        exp_fd_q.push_back({32'h8, 32'hA5A5_0008});
        exp_fd_q.push_back({32'hC, 32'hA5A5_000C});
        fetch_n(4, span);
        chk32("stream_span", 32'(span), 32'd6);
        drain(4);

        // Decode back-pressure for 5 cycles
        sync();
        fd_ready       = 1'b0;
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h14);
        exp_fd_q.push_back({32'h10, 32'hA5A5_0010});
        exp_fd_q.push_back({32'h14, 32'hA5A5_0014});
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fd_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk1("stall_fd_seen", got, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk1 ("stall_fd_valid", fd_valid, 1'b1);
            chk32("stall_fd_pc", fd_pc, 32'h10);
            chk32("stall_fd_instr", fd_instruction, 32'hA5A5_0010);
            chk1 ("stall_no_req", imem_req_valid, 1'b0);
            if (i < 4) @(negedge clock);
        end
        sync();
        fd_ready = 1'b1;
        @(negedge clock);
        chk1("unstall_req", imem_req_valid, 1'b1);
        sync();
        imem_req_ready = 1'b0;
        drain(4);

        // Redirect while waiting on a 3-cycle response
        sync();
        lat            = 3;
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(32'h18);
        wait_hs();
        sync();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clock);
        chk1("redir_wait_no_req", imem_req_valid, 1'b0);
        sync();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk1("drain_fd_valid_a", fd_valid, 1'b0);
        chk1("drain_no_req_a", imem_req_valid, 1'b0);
        sync();
        @(negedge clock);
        chk1("drain_fd_valid_b", fd_valid, 1'b0);
        chk1("drain_no_req_b", imem_req_valid, 1'b0);
        sync();
        @(negedge clock);
        chk1 ("drain_done_req", imem_req_valid, 1'b1);
        chk32("drain_done_addr", imem_addr, 32'h0000_0100);
        chk1 ("drain_dropped", fd_valid, 1'b0);
        lat = 1;
        exp_addr_q.push_back(32'h100);
        exp_fd_q.push_back({32'h100, 32'hA5A5_0100});
        fetch_n(1, span);
        drain(4);

        // Redirect in the same cycle as the response
        sync();
        lat            = 2;
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(32'h104);
        wait_hs();
        sync();
        imem_req_ready = 1'b0;
        sync();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(32'h200);
        exp_fd_q.push_back({32'h200, 32'hA5A5_0200});
        @(negedge clock);
        chk1("redir_rsp_no_req", imem_req_valid, 1'b0);
        sync();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk1 ("redir_rsp_req", imem_req_valid, 1'b1);
        chk32("redir_rsp_addr", imem_addr, 32'h0000_0200);
        chk1 ("redir_rsp_dropped", fd_valid, 1'b0);
        sync();
        imem_req_ready = 1'b0;
        drain(5);

        // Redirect flushes a word that decode is holding off
        sync();
        lat            = 1;
        fd_ready       = 1'b0;
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(32'h204);
        wait_hs();
        sync();
        imem_req_ready = 1'b0;
        sync();
        @(negedge clock);
        chk1 ("flush_pre_valid", fd_valid, 1'b1);
        chk32("flush_pre_pc", fd_pc, 32'h204);
        sync();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_030A;
        @(negedge clock);
        chk1("flush_hold", fd_valid, 1'b1);
        chk1("flush_no_req", imem_req_valid, 1'b0);
        sync();
        redirect_valid = 1'b0;
        fd_ready       = 1'b1;
        @(negedge clock);
        chk1 ("flush_cleared", fd_valid, 1'b0);
        chk1 ("flush_req", imem_req_valid, 1'b1);
        chk32("flush_addr", imem_addr, 32'h0000_0308);
        exp_addr_q.push_back(32'h308);
        exp_fd_q.push_back({32'h308, 32'hA5A5_0308});
        fetch_n(1, span);
        drain(4);

        // Redirect in S_REQ to the top of memory; PC wraps to 0
        sync();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clock);
        chk1("redir_req_no_req", imem_req_valid, 1'b0);
        sync();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk32("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        exp_fd_q.push_back({32'hFFFF_FFFC, 32'hA5A5_FFFC});
        exp_fd_q.push_back({32'h0, 32'hA5A5_0000});
        fetch_n(2, span);
        drain(4);

        // Reset while waiting on a response
        sync();
        lat            = 4;
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(32'h4);
        wait_hs();
        sync();
        imem_req_ready = 1'b0;
        reset          = 1'b1;
        @(negedge clock);
        chk1("midrst_req_valid", imem_req_valid, 1'b0);
        sync();
        reset = 1'b0;
        @(negedge clock);
        chk1 ("midrst_fd_valid", fd_valid, 1'b0);
        chk32("midrst_fd_instr", fd_instruction, 32'h0000_0013);
        chk32("midrst_fd_pc", fd_pc, 32'h0);
        chk32("midrst_addr", imem_addr, 32'h0);
        chk1 ("midrst_req", imem_req_valid, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk1("midrst_no_stale", fd_valid, 1'b0);
        end
        lat = 1;
        exp_addr_q.push_back(32'h0);
        exp_fd_q.push_back({32'h0, 32'hA5A5_0000});
        fetch_n(1, span);
        drain(4);

        @(negedge clock);
        chk32("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
        chk32("fd_q_left", 32'(exp_fd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
